// File: rtl/flag_register.sv
// Condition-flag register {Z,C,N,V} with masked update, a one-deep registered
// condition evaluator (valid/ready) and a LIFO save/restore stack.
module flag_register #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zero_in,
    input  logic       carry_in,
    input  logic       negative_in,
    input  logic       overflow_in,
    input  logic       update,
    input  logic [3:0] flag_mask,
    output logic [3:0] flags,
    input  logic       eval_valid,
    input  logic [3:0] cond,
    output logic       eval_ready,
    output logic       taken_valid,
    output logic       taken,
    input  logic       taken_ready,
    input  logic       push,
    input  logic       pop,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       error
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [3:0]    flags_q, flags_d;
    logic [CW-1:0] count_q, count_d;
    logic          taken_valid_q, taken_valid_d;
    logic          taken_q, taken_d;
    logic          error_q, error_d;
    logic [3:0]    stack_q [STACK_DEPTH];

    logic          full, empty;
    logic          push_ok, pop_ok;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [3:0]    upd_flags;
    logic          cond_true;
    logic          z, c, n, v;

    assign {z, c, n, v} = flags_q;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(STACK_DEPTH));
    assign wr_idx = AW'(count_q);
    assign rd_idx = AW'(count_q - CW'(1));

    // Simultaneous push+pop is treated as misuse and leaves the stack untouched.
    assign push_ok = push && !pop && !full;
    assign pop_ok  = pop && !push && !empty;
    assign error_d = (push && pop) || (push && full) || (pop && empty);

    assign upd_flags = (flags_q & ~flag_mask)
                     | ({zero_in, carry_in, negative_in, overflow_in} & flag_mask);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:  cond_true = z;
            4'd1:  cond_true = !z;
            4'd2:  cond_true = c;
            4'd3:  cond_true = !c;
            4'd4:  cond_true = n;
            4'd5:  cond_true = !n;
            4'd6:  cond_true = v;
            4'd7:  cond_true = !v;
            4'd8:  cond_true = c && !z;
            4'd9:  cond_true = !c || z;
            4'd10: cond_true = (n == v);
            4'd11: cond_true = (n != v);
            4'd12: cond_true = !z && (n == v);
            4'd13: cond_true = z || (n != v);
            4'd14: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        count_d = count_q;
        if (pop_ok) begin
            flags_d = stack_q[rd_idx];
            count_d = count_q - CW'(1);
        end else begin
            if (update) flags_d = upd_flags;
            if (push_ok) count_d = count_q + CW'(1);
        end
    end

    assign eval_ready = !taken_valid_q || taken_ready;

    always_comb begin
        taken_valid_d = taken_valid_q;
        taken_d       = taken_q;
        if (eval_valid && eval_ready) begin
            taken_valid_d = 1'b1;
            taken_d       = cond_true;
        end else if (taken_ready) begin
            taken_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q       <= 4'b0000;
            count_q       <= '0;
            taken_valid_q <= 1'b0;
            taken_q       <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            count_q       <= count_d;
            taken_valid_q <= taken_valid_d;
            taken_q       <= taken_d;
            error_q       <= error_d;
        end
    end

    // Entry contents need no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (push_ok) stack_q[wr_idx] <= flags_q;
    end

    assign flags       = flags_q;
    assign taken_valid = taken_valid_q;
    assign taken       = taken_q;
    assign error       = error_q;
    assign stack_empty = empty;
    assign stack_full  = full;

endmodule
